// File: rtl/u_xmit_arb.sv
// Round-robin arbiter sharing one UART transmitter between two byte-stream requesters,
// with multi-byte packet locking and a hold-timeout that releases a stalled lock.
module u_xmit_arb #(
  parameter int LOCK_TMO = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       req0H,
  input  logic [7:0] data0H,
  input  logic       last0H,
  output logic       ack0H,
  input  logic       req1H,
  input  logic [7:0] data1H,
  input  logic       last1H,
  output logic       ack1H,
  output logic       xmitH,
  output logic [7:0] xmit_dataH,
  input  logic       xmit_doneH,
  output logic [1:0] grantH,
  output logic       tmo_errH
);

  typedef enum logic [1:0] {IDLE, SEND, BUSY, HOLD} state_t;

  localparam logic [7:0] TMO_LAST = 8'(LOCK_TMO - 1);

  state_t     state, stateNxt;
  logic       favour1, favour1Nxt;
  logic [7:0] tmoCnt, tmoCntNxt;
  logic       lastCap, lastCapNxt;
  logic [7:0] dataNxt;
  logic [1:0] grantNxt;
  logic       xmitNxt, ack0Nxt, ack1Nxt, tmoNxt;
  logic       pick1, ownerReq, ownerLast;
  logic [7:0] ownerData;

  function automatic logic [7:0] satInc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    stateNxt   = state;
    favour1Nxt = favour1;
    tmoCntNxt  = tmoCnt;
    lastCapNxt = lastCap;
    dataNxt    = xmit_dataH;
    grantNxt   = grantH;
    xmitNxt    = 1'b0;
    ack0Nxt    = 1'b0;
    ack1Nxt    = 1'b0;
    tmoNxt     = 1'b0;
    // favour1 breaks ties only; a lone requester always wins
    pick1      = req1H && (!req0H || favour1);
    ownerReq   = grantH[1] ? req1H  : req0H;
    ownerData  = grantH[1] ? data1H : data0H;
    ownerLast  = grantH[1] ? last1H : last0H;

    case (state)
      IDLE: begin
        if (req0H || req1H) begin
          stateNxt   = SEND;
          grantNxt   = pick1 ? 2'b10 : 2'b01;
          dataNxt    = pick1 ? data1H : data0H;
          lastCapNxt = pick1 ? last1H : last0H;
          xmitNxt    = 1'b1;
          ack0Nxt    = !pick1;
          ack1Nxt    = pick1;
        end
      end
      SEND: stateNxt = BUSY;
      BUSY: begin
        if (xmit_doneH) begin
          if (lastCap) begin
            favour1Nxt = grantH[0];
            grantNxt   = 2'b00;
            stateNxt   = IDLE;
          end else begin
            tmoCntNxt = 8'd0;
            stateNxt  = HOLD;
          end
        end
      end
      HOLD: begin
        // owner request takes precedence over an expiring timeout
        if (ownerReq) begin
          stateNxt   = SEND;
          dataNxt    = ownerData;
          lastCapNxt = ownerLast;
          tmoCntNxt  = 8'd0;
          xmitNxt    = 1'b1;
          ack0Nxt    = grantH[0];
          ack1Nxt    = grantH[1];
        end else if (tmoCnt == TMO_LAST) begin
          tmoNxt     = 1'b1;
          favour1Nxt = grantH[0];
          grantNxt   = 2'b00;
          stateNxt   = IDLE;
        end else begin
          tmoCntNxt = satInc(tmoCnt);
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      favour1    <= 1'b0;
      tmoCnt     <= 8'd0;
      lastCap    <= 1'b0;
      xmit_dataH <= 8'd0;
      grantH     <= 2'b00;
      xmitH      <= 1'b0;
      ack0H      <= 1'b0;
      ack1H      <= 1'b0;
      tmo_errH   <= 1'b0;
    end else begin
      state      <= stateNxt;
      favour1    <= favour1Nxt;
      tmoCnt     <= tmoCntNxt;
      lastCap    <= lastCapNxt;
      xmit_dataH <= dataNxt;
      grantH     <= grantNxt;
      xmitH      <= xmitNxt;
      ack0H      <= ack0Nxt;
      ack1H      <= ack1Nxt;
      tmo_errH   <= tmoNxt;
    end
  end

endmodule

// File: tb/tb_u_xmit_arb.sv
// Bench for u_xmit_arb: directed scenarios followed by randomized traffic, all checked
// every cycle against a transaction-level reference model.
module tb_u_xmit_arb;

  localparam int TMO = 4;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       req0H = 1'b0, last0H = 1'b0, req1H = 1'b0, last1H = 1'b0;
  logic [7:0] data0H = 8'd0, data1H = 8'd0;
  logic       xmit_doneH = 1'b0;
  logic       ack0H, ack1H, xmitH, tmo_errH;
  logic [7:0] xmit_dataH;
  logic [1:0] grantH;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  u_xmit_arb #(.LOCK_TMO(TMO)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .req0H(req0H), .data0H(data0H), .last0H(last0H), .ack0H(ack0H),
    .req1H(req1H), .data1H(data1H), .last1H(last1H), .ack1H(ack1H),
    .xmitH(xmitH), .xmit_dataH(xmit_dataH), .xmit_doneH(xmit_doneH),
    .grantH(grantH), .tmo_errH(tmo_errH)
  );

  // Reference model: who owns the transmitter, whether a byte is being strobed or
  // is in flight, whether the owner holds a lock, and how long the lock has idled.
  int         mOwner, mFav, mHoldIdle;
  bit         mStrobe, mInFlight, mLocked, mMore;
  logic       eXmit, eAck0, eAck1, eTmo;
  logic [7:0] eData;
  logic [1:0] eGrant;

  task automatic chkB(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkV(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mOwner = -1; mFav = 0; mHoldIdle = 0;
    mStrobe = 0; mInFlight = 0; mLocked = 0; mMore = 0;
    eXmit = 0; eAck0 = 0; eAck1 = 0; eTmo = 0; eData = 8'd0; eGrant = 2'b00;
  endtask

  task automatic modelTake(input int w, input logic [7:0] d, input logic l);
    mOwner  = w;
    eData   = d;
    mMore   = !l;
    mStrobe = 1;
    eXmit   = 1;
    eAck0   = (w == 0);
    eAck1   = (w == 1);
  endtask

  task automatic modelStep();
    bit         r[2];
    logic [7:0] d[2];
    logic       l[2];
    int         w;
    if (sys_rst) begin
      modelReset();
      return;
    end
    r[0] = req0H; r[1] = req1H;
    d[0] = data0H; d[1] = data1H;
    l[0] = last0H; l[1] = last1H;
    eXmit = 0; eAck0 = 0; eAck1 = 0; eTmo = 0;
    if (mStrobe) begin
      mStrobe   = 0;
      mInFlight = 1;
    end else if (mInFlight) begin
      if (xmit_doneH) begin
        mInFlight = 0;
        if (mMore) begin
          mLocked   = 1;
          mHoldIdle = 0;
        end else begin
          mFav   = 1 - mOwner;
          mOwner = -1;
        end
      end
    end else if (mLocked) begin
      if (r[mOwner]) begin
        mLocked = 0;
        modelTake(mOwner, d[mOwner], l[mOwner]);
      end else begin
        mHoldIdle++;
        if (mHoldIdle == TMO) begin
          eTmo    = 1;
          mLocked = 0;
          mFav    = 1 - mOwner;
          mOwner  = -1;
        end
      end
    end else begin
      w = -1;
      if (r[0] && r[1]) w = mFav;
      else if (r[0]) w = 0;
      else if (r[1]) w = 1;
      if (w >= 0) modelTake(w, d[w], l[w]);
    end
    eGrant = (mOwner < 0) ? 2'b00 : ((mOwner == 0) ? 2'b01 : 2'b10);
  endtask

  task automatic tick();
    modelStep();
    @(posedge sys_clk);
    #1;
    chkB("xmit", xmitH, eXmit);
    chkB("ack0", ack0H, eAck0);
    chkB("ack1", ack1H, eAck1);
    chkB("tmo_err", tmo_errH, eTmo);
    chkV("xmit_data", xmit_dataH, eData);
    chkV("grant", {6'd0, grantH}, {6'd0, eGrant});
  endtask

  task automatic waitXmit();
    int n = 0;
    tick();
    while (!xmitH && n < 10) begin
      tick();
      n++;
    end
    chkB("xmit_wait", xmitH, 1'b1);
  endtask

  task automatic pulseDone(input int busyCycles);
    repeat (busyCycles) tick();
    xmit_doneH = 1'b1;
    tick();
    xmit_doneH = 1'b0;
  endtask

  initial begin
    int ackCnt0 = 0, ackCnt1 = 0, waitN = 0;
    bit outst = 0;

    modelReset();
    tick();
    tick();
    sys_rst = 1'b0;

    // simultaneous requests alternate
    req0H = 1; data0H = 8'h11; last0H = 1;
    req1H = 1; data1H = 8'h22; last1H = 1;
    for (int i = 0; i < 4; i++) begin
      waitXmit();
      chkV("rr_grant", {6'd0, grantH}, (i % 2 == 1) ? 8'h02 : 8'h01);
      chkV("rr_data", xmit_dataH, (i % 2 == 1) ? 8'h22 : 8'h11);
      pulseDone(2);
    end
    req0H = 0; req1H = 0;
    tick();

    // locked 3-byte packet from requester 1 while requester 0 waits
    req1H = 1; data1H = 8'h31; last1H = 0;
    for (int b = 0; b < 3; b++) begin
      waitXmit();
      chkV("lock_grant", {6'd0, grantH}, 8'h02);
      chkV("lock_data", xmit_dataH, 8'(8'h31 + b));
      if (b == 0) begin req0H = 1; data0H = 8'h44; last0H = 1; end
      tick();
      if (b < 2) begin
        data1H = 8'(8'h32 + b);
        last1H = (b == 1);
      end else begin
        req1H = 0;
      end
      pulseDone(1);
    end
    waitXmit();
    chkV("lock_after_grant", {6'd0, grantH}, 8'h01);
    chkV("lock_after_data", xmit_dataH, 8'h44);
    tick();
    req0H = 0;
    pulseDone(1);

    // spurious done while idle
    xmit_doneH = 1;
    tick();
    xmit_doneH = 0;
    chkV("spur_idle_grant", {6'd0, grantH}, 8'h00);
    chkB("spur_idle_ack0", ack0H, 1'b0);

    // single byte
    req0H = 1; data0H = 8'hA5; last0H = 1;
    tick();
    chkB("single_xmit", xmitH, 1'b1);
    chkB("single_ack0", ack0H, 1'b1);
    chkV("single_data", xmit_dataH, 8'hA5);
    chkV("single_grant", {6'd0, grantH}, 8'h01);
    tick();
    req0H = 0;
    chkV("single_busy_grant", {6'd0, grantH}, 8'h01);
    xmit_doneH = 1;
    tick();
    xmit_doneH = 0;
    chkV("single_done_grant", {6'd0, grantH}, 8'h00);

    // lock then stall: spurious done in HOLD, then timeout; requester 1 waits
    req0H = 1; data0H = 8'h55; last0H = 0;
    tick();
    tick();
    req0H = 0;
    req1H = 1; data1H = 8'h66; last1H = 1;
    xmit_doneH = 1;
    tick();
    xmit_doneH = 1;
    tick();
    xmit_doneH = 0;
    chkV("spur_hold_grant", {6'd0, grantH}, 8'h01);
    chkB("spur_hold_ack1", ack1H, 1'b0);
    chkB("spur_hold_tmo", tmo_errH, 1'b0);
    tick();
    tick();
    chkB("tmo_not_yet", tmo_errH, 1'b0);
    tick();
    chkB("tmo_pulse", tmo_errH, 1'b1);
    chkV("tmo_grant", {6'd0, grantH}, 8'h00);
    tick();
    chkV("tmo_next_grant", {6'd0, grantH}, 8'h02);
    chkV("tmo_next_data", xmit_dataH, 8'h66);
    tick();
    req1H = 0;
    pulseDone(1);

    // reset during BUSY while the pointer favours requester 1
    req0H = 1; data0H = 8'h77; last0H = 1;
    waitXmit();
    tick();
    req0H = 0;
    pulseDone(1);
    req0H = 1; data0H = 8'h78;
    waitXmit();
    tick();
    req0H = 0;
    #2;
    sys_rst = 1;
    #1;
    chkB("rst_xmit", xmitH, 1'b0);
    chkB("rst_ack0", ack0H, 1'b0);
    chkB("rst_ack1", ack1H, 1'b0);
    chkB("rst_tmo", tmo_errH, 1'b0);
    chkV("rst_grant", {6'd0, grantH}, 8'h00);
    chkV("rst_data", xmit_dataH, 8'h00);
    modelReset();
    tick();
    sys_rst = 0;
    tick();
    chkB("rst_no_reissue", xmitH, 1'b0);
    req0H = 1; data0H = 8'h81; last0H = 1;
    req1H = 1; data1H = 8'h82; last1H = 1;
    tick();
    chkV("rst_prio_grant", {6'd0, grantH}, 8'h01);
    chkV("rst_prio_data", xmit_dataH, 8'h81);
    tick();
    req0H = 0; req1H = 0;
    pulseDone(1);

    // randomized traffic obeying the requester and transmitter contracts
    for (int c = 0; c < 3000; c++) begin
      if (ackCnt0 > 0) begin
        ackCnt0--;
        if (ackCnt0 == 0) begin
          if ($urandom_range(0, 1) == 0) req0H = 0;
          else begin data0H = 8'($urandom); last0H = 1'($urandom); end
        end
      end else if (!req0H && $urandom_range(0, 2) == 0) begin
        req0H = 1; data0H = 8'($urandom); last0H = 1'($urandom);
      end
      if (ackCnt1 > 0) begin
        ackCnt1--;
        if (ackCnt1 == 0) begin
          if ($urandom_range(0, 1) == 0) req1H = 0;
          else begin data1H = 8'($urandom); last1H = 1'($urandom); end
        end
      end else if (!req1H && $urandom_range(0, 2) == 0) begin
        req1H = 1; data1H = 8'($urandom); last1H = 1'($urandom);
      end
      if (outst) begin
        if (waitN == 0) begin
          xmit_doneH = 1;
          outst = 0;
        end else begin
          xmit_doneH = 0;
          waitN--;
        end
      end else begin
        xmit_doneH = ($urandom_range(0, 9) == 0);
      end
      tick();
      if (ack0H) ackCnt0 = 2;
      if (ack1H) ackCnt1 = 2;
      if (xmitH) begin
        outst = 1;
        waitN = $urandom_range(1, 5);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/u_xmit_arb.md
# u_xmit_arb

Round-robin arbiter that shares the single UART transmitter between two byte-stream requesters. It grants one requester at a time and issues one-cycle transmit strobes. It then waits for the transmitter's done pulse before the next byte. A requester can lock the transmitter across a multi-byte packet; a hold-timeout releases a stalled lock. It sits between the command/response sources and the UART transmit datapath, mirroring the receive path on the other side.

## Interface
- LOCK_TMO, 16: cycles a locked owner may leave the transmitter idle in HOLD before the lock is forcibly released; legal range 1..255.
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  asynchronous, active-high reset.
- req0H  in  1  requester 0 has a byte on data0H.
- data0H  in  8  requester 0 byte.
- last0H  in  1  byte on data0H is last of packet; 0 = keep lock after this byte.
- ack0H  out  1  one-cycle pulse: data0H was taken this cycle.
- req1H, data1H, last1H, ack1H: same as requester 0, for requester 1.
- xmitH  out  1  one-cycle transmit strobe to the UART transmitter.
- xmit_dataH  out  8  byte to transmit; valid when xmitH is high, held until the next strobe.
- xmit_doneH  in  1  one-cycle pulse from the transmitter: byte fully shifted out.
- grantH  out  2  one-hot current owner; 00 when IDLE.
- tmo_errH  out  1  one-cycle pulse: lock released by timeout.

## Operation
- Reset state of every output: ack0H, ack1H, xmitH, tmo_errH, grantH, and xmit_dataH are all 0. State is IDLE. The priority pointer favours requester 0. The timeout counter is 0.
- States: IDLE, SEND, BUSY, HOLD.
- IDLE
  - Only one reqH high: that requester wins.
  - Both high: the requester not served by the most recent completed grant wins.
  - Winner's data and last are registered, grantH is set, and the next state is SEND.
  - No requests: stay in IDLE.
- SEND, exactly 1 cycle
  - xmitH = 1, xmit_dataH = captured byte, and ack of the owner = 1.
  - Next state is BUSY.
- BUSY: wait for xmit_doneH.
  - On done with captured last = 1: the pointer now favours the other requester, grantH clears, and the next state is IDLE.
  - On done with last = 0: the timeout counter clears and the next state is HOLD. grantH is held.
- HOLD: only the owner's reqH is examined.
  - Owner reqH high: capture data/last, clear the counter, and go to SEND.
  - Otherwise the counter increments.
  - When the counter equals LOCK_TMO-1 with no owner request: pulse tmo_errH, update the pointer as for a completed packet, clear grantH, and go to IDLE.
  - Owner request and timeout in the same cycle: the request wins and there is no error.
- The non-owner's reqH is ignored in SEND, BUSY and HOLD. It receives no ack.
- xmit_doneH outside BUSY is ignored and does not change state.
- Requester contract:
  - Hold reqH/data/last stable until ack.
  - The cycle after ack, deassert reqH or present the next byte.
- Reset mid-operation (any state): return to IDLE immediately and clear all outputs. A byte already strobed is not re-issued after reset.

## Timing
- reqH high in cycle n while IDLE (or HOLD for the owner) gives xmitH and ack in cycle n+1.
- xmit_doneH sampled in cycle m (BUSY) gives IDLE or HOLD in cycle m+1. The earliest next xmitH is in cycle m+2.
- The timeout fires on the LOCK_TMO-th consecutive HOLD cycle without an owner request. tmo_errH is high in the cycle the state returns to IDLE.
- The timeout counter is 8 bits, saturating, and cleared on entry to HOLD.
- All outputs are registered; no combinational path from input to output.

## Test plan
- Single byte: req0H=1, data0H=8'hA5, last0H=1 from IDLE. Required: xmitH, ack0H, and xmit_dataH=A5 one cycle later; grantH=01 until done. After xmit_doneH, grantH=00 on the next cycle.
- Simultaneous requests: req0 and req1 both held high, each byte with last=1, data 8'h11/8'h22. Required: grants alternate 0,1,0,1 and xmit_dataH sequence is 11,22,11,22.
- Locked packet: requester 1 sends 3 bytes (last=0,0,1) while req0 is held high throughout. Required: all 3 bytes go to requester 1 back-to-back, and requester 0 is granted only after the third done.
- Hold timeout: LOCK_TMO=4, requester 0 sends one byte with last=0 then drops req. Required: tmo_errH pulses on the 4th HOLD cycle and grantH=00. A waiting req1 is granted in the following cycle.
- Spurious done: pulse xmit_doneH while in IDLE and in HOLD. Required: no state change and no ack.
- Reset mid-operation: assert sys_rst during BUSY. Required: all outputs 0 asynchronously and IDLE after release. Requester 0 has priority on the first conflict.
